if_fetch: RTL
=============

IF_FETCH -- requirements
Module: if_fetch

Interface
REQ-001 SHALL have parameter RESET_PC, default 32'hBFC0_0000, the first fetch address after reset.
REQ-002 SHALL have port clk, input, 1, the single clock; all state updates on posedge clk.
REQ-003 SHALL have port rst, input, 1, the reset: synchronous, active-low.
REQ-004 SHALL have port stall, input, 6, the pipeline stall vector; bit 0 holds the PC, bit 1 holds IF/ID.
REQ-005 SHALL have port br_bus, input, 33, {br_e, br_addr[31:0]}, the redirect request from the decode stage.
REQ-006 SHALL have port if_to_id_bus, output, 33, {ce, pc[31:0]}, the current fetch descriptor.
REQ-007 SHALL have port inst_sram_en, output, 1, the instruction memory enable.
REQ-008 SHALL have port inst_sram_wen, output, 4, the byte write enables; constant 0.
REQ-009 SHALL have port inst_sram_addr, output, 32, the fetch address.
REQ-010 SHALL have port inst_sram_wdata, output, 32, the write data; constant 0.

Function
REQ-011 SHALL keep registers pc_reg[31:0], ce_reg, pend_v and pend_addr[31:0], plus a state register.
REQ-012 SHALL drive outputs from registers only: if_to_id_bus={ce_reg,pc_reg}, inst_sram_en=ce_reg, inst_sram_addr=pc_reg.
REQ-013 SHALL have states FS_RESET, FS_RUN, FS_HOLD and FS_HOLD_BR.
REQ-014 FS_RESET SHALL go to FS_RUN on the first clock with rst high, loading pc_reg=RESET_PC and ce_reg=1.
REQ-015 In FS_RUN with stall[0]=0, pc_reg SHALL load br_addr if br_e=1, else pc_reg+4, with wrap-around modulo 2^32.
REQ-016 In FS_RUN with stall[0]=1, pc_reg and ce_reg SHALL hold; next state SHALL be FS_HOLD_BR with pend_v=1 and pend_addr=br_addr if br_e=1, else FS_HOLD.
REQ-017 In FS_HOLD with stall[0]=1 and br_e=1, the block SHALL capture pend_addr and go to FS_HOLD_BR; with stall[0]=0 it SHALL behave as FS_RUN does for the same inputs and return to FS_RUN.
REQ-018 In FS_HOLD_BR with stall[0]=1 and br_e=1, pend_addr SHALL be overwritten so the latest redirect wins.
REQ-019 In FS_HOLD_BR with stall[0]=0: pc_reg SHALL load br_addr if br_e=1, else pend_addr; pend_v SHALL clear; next state SHALL be FS_RUN.
REQ-020 Redirect priority SHALL be live br_e, then pend_addr, then pc_reg+4.
REQ-021 A redirect SHALL take effect on inst_sram_addr exactly one clock after the un-stalled cycle in which br_e or the pending branch is consumed, with no bubble inserted by this block.
REQ-022 stall[5:1] SHALL be ignored.

Reset
REQ-023 With rst=0 at a clock edge, in any state and even mid-stall or mid-pending: pc_reg=RESET_PC-4, ce_reg=0, pend_v=0, pend_addr=0, state=FS_RESET.
REQ-024 During reset the outputs SHALL be: if_to_id_bus={1'b0,RESET_PC-4}, inst_sram_en=0, inst_sram_wen=0, inst_sram_wdata=0.

Configuration
REQ-025 With IF_ADDR_EXC_EN defined, the block SHALL add output port if_adel (1 bit), a registered flag set when pc_reg[1:0]!=0 with ce_reg=1; in that case inst_sram_en SHALL be 0 while if_to_id_bus is unchanged.
REQ-026 Without IF_ADDR_EXC_EN, port if_adel SHALL be absent and the block SHALL perform no alignment check.

Structure
REQ-027 StallBus (6), IF_TO_ID_WD (33), BR_WD (33) and the FS_* state encodings SHALL live in the shared defines header; the Stop/NoStop constants SHALL be reused from it.
REQ-028 The block SHALL have a single module with no sub-module; the next-PC mux SHALL be inline.

Verification
REQ-029 Reset release: rst low for 3 cycles, then high -> addr=BFBFFFFC with en=0 during reset, then BFC00000 with en=1, then BFC00004.
REQ-030 Branch: br_e=1 with br_addr=BFC00100 while pc=BFC00008, no stall -> next addr BFC00100, then BFC00104.
REQ-031 Stall with branch: stall[0]=1 for 3 cycles, br_e pulsed in the first cycle with 8000_0040 -> pc held, then 8000_0040 after release.
REQ-032 Overwrite: within one stall window, br 1000_0000 then br 2000_0000, with br_e=0 on release -> 2000_0000.
REQ-033 Wrap and reset mid-pending: br_addr=FFFF_FFFC -> next addr 0000_0000; rst=0 while in FS_HOLD_BR -> pend cleared, restart at BFC00000.
REQ-034 With IF_ADDR_EXC_EN: br_addr=BFC00102 -> if_adel=1, en=0, if_to_id_bus={1,BFC00102}.

Source files
------------

// File: rtl/if_fetch_pkg.sv
// ============================================================================
//  Module      : if_fetch_pkg
//  Description : Shared widths, stall constants and fetch-FSM encodings.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package if_fetch_pkg;

    localparam int STALL_BUS_WD = 6;
    localparam int IF_TO_ID_WD  = 33;
    localparam int BR_WD        = 33;

    localparam logic STOP    = 1'b1;
    localparam logic NO_STOP = 1'b0;

    localparam logic [1:0] FS_RESET   = 2'd0;
    localparam logic [1:0] FS_RUN     = 2'd1;
    localparam logic [1:0] FS_HOLD    = 2'd2;
    localparam logic [1:0] FS_HOLD_BR = 2'd3;

endpackage

`default_nettype wire

// File: rtl/if_fetch.sv
// ============================================================================
//  Module      : if_fetch
//  Description : Instruction fetch PC generator with stall-safe branch capture.
//                Optional IF_ADDR_EXC_EN adds the misaligned-fetch flag if_adel.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module if_fetch
    import if_fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'hBFC0_0000
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [STALL_BUS_WD-1:0] stall,
    input  logic [BR_WD-1:0]        br_bus,
    output logic [IF_TO_ID_WD-1:0]  if_to_id_bus,
`ifdef IF_ADDR_EXC_EN
    output logic                    if_adel,
`endif
    output logic                    inst_sram_en,
    output logic [3:0]              inst_sram_wen,
    output logic [31:0]             inst_sram_addr,
    output logic [31:0]             inst_sram_wdata
);

    logic [1:0]  state_q, state_d;
    logic [31:0] pc_reg_q, pc_reg_d;
    logic        ce_reg_q, ce_reg_d;
    logic        pend_v_q, pend_v_d;
    logic [31:0] pend_addr_q, pend_addr_d;

    logic        br_e;
    logic [31:0] br_addr;
    logic        w_unused_stall;

    assign br_e           = br_bus[32];
    assign br_addr        = br_bus[31:0];
    assign w_unused_stall = ^stall[5:1];

`ifdef IF_ADDR_EXC_EN
    logic adel_q, adel_d;
    assign adel_d = ce_reg_d && (pc_reg_d[1:0] != 2'b00);
`endif

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q     <= FS_RESET;
            pc_reg_q    <= RESET_PC - 32'd4;
            ce_reg_q    <= 1'b0;
            pend_v_q    <= 1'b0;
            pend_addr_q <= 32'h0;
`ifdef IF_ADDR_EXC_EN
            adel_q      <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            pc_reg_q    <= pc_reg_d;
            ce_reg_q    <= ce_reg_d;
            pend_v_q    <= pend_v_d;
            pend_addr_q <= pend_addr_d;
`ifdef IF_ADDR_EXC_EN
            adel_q      <= adel_d;
`endif
        end
    end

    // Redirect priority: live branch, then captured branch, then sequential.
    always_comb begin
        state_d     = state_q;
        pc_reg_d    = pc_reg_q;
        ce_reg_d    = ce_reg_q;
        pend_v_d    = pend_v_q;
        pend_addr_d = pend_addr_q;
        case (state_q)
            FS_RESET: begin
                pc_reg_d = RESET_PC;
                ce_reg_d = 1'b1;
                state_d  = FS_RUN;
            end
            FS_RUN, FS_HOLD: begin
                if (stall[0] == NO_STOP) begin
                    pc_reg_d = br_e ? br_addr : pc_reg_q + 32'd4;
                    ce_reg_d = 1'b1;
                    state_d  = FS_RUN;
                end else if (br_e) begin
                    pend_v_d    = 1'b1;
                    pend_addr_d = br_addr;
                    state_d     = FS_HOLD_BR;
                end else begin
                    state_d = FS_HOLD;
                end
            end
            FS_HOLD_BR: begin
                if (stall[0] == NO_STOP) begin
                    if (br_e)
                        pc_reg_d = br_addr;
                    else if (pend_v_q)
                        pc_reg_d = pend_addr_q;
                    else
                        pc_reg_d = pc_reg_q + 32'd4;
                    ce_reg_d = 1'b1;
                    pend_v_d = 1'b0;
                    state_d  = FS_RUN;
                end else if (br_e) begin
                    pend_addr_d = br_addr;
                end
            end
            default: begin
                state_d = FS_RESET;
            end
        endcase
    end

    always_comb begin
        if_to_id_bus    = {ce_reg_q, pc_reg_q};
        inst_sram_addr  = pc_reg_q;
        inst_sram_wen   = 4'h0;
        inst_sram_wdata = 32'h0;
`ifdef IF_ADDR_EXC_EN
        if_adel         = adel_q;
        inst_sram_en    = ce_reg_q & ~adel_q;
`else
        inst_sram_en    = ce_reg_q;
`endif
    end

endmodule

`default_nettype wire
